// File: rtl/ray_column_renderer.sv
`default_nettype none
// ray_column_renderer: expands one DDA column descriptor into SCREEN_HEIGHT RGB565 frame-buffer writes.
// Optional macro RAY_SHADE_EN halves each wall colour channel for wall type 1.
module ray_column_renderer #(
   parameter int          SCREEN_WIDTH  = 320,
   parameter int          SCREEN_HEIGHT = 180,
   parameter logic [15:0] CEIL_COLOR    = 16'hFFFF,
   parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
   localparam int         ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
   localparam int         VC_WIDTH      = $clog2(SCREEN_HEIGHT)
) (
   input  logic                  pixel_clk_in,
   input  logic                  rst_n_in,
   input  logic                  dda_fifo_tvalid_in,
   input  logic [37:0]           dda_fifo_tdata_in,
   input  logic                  dda_fifo_tlast_in,
   input  logic [1:0]            fb_ready_to_switch_in,
   output logic                  transformer_tready_out,
   input  logic                  pixel_ready_in,
   output logic                  pixel_valid_out,
   output logic [ADDR_WIDTH-1:0] ray_address_out,
   output logic [15:0]           ray_pixel_out,
   output logic                  ray_last_pixel_out,
   output logic                  err_out
);

   typedef enum logic [1:0] {IDLE, RENDER, WAIT_FRAME} state_t;

   localparam logic [10:0]         HALF_H  = 11'(SCREEN_HEIGHT/2);
   localparam logic [10:0]         FULL_H  = 11'(SCREEN_HEIGHT);
   localparam logic [9:0]          WIDTH_C = 10'(SCREEN_WIDTH);
   localparam logic [VC_WIDTH-1:0] LAST_ROW = VC_WIDTH'(SCREEN_HEIGHT-1);

   state_t                state_q, state_d;
   logic                  rdy_q;
   logic [10:0]           start_q, start_d, end_q, end_d;
   logic [3:0]            map_q, map_d;
   logic                  tlast_q, tlast_d;
   logic [VC_WIDTH-1:0]   vcount_q, vcount_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           pix_q, pix_d;
   logic                  valid_q, valid_d, last_q, last_d, err_q, err_d;

   logic [8:0]            in_hcount;
   logic [7:0]            in_lh;
   logic [3:0]            in_map;
   logic signed [10:0]    half_s, start_s, end_s;
   logic [10:0]           in_start, in_end;
   logic                  accept;
   logic [VC_WIDTH-1:0]   next_row;
   logic [15:0]           wall_in, wall_q;
   logic [16:0]           unused_w;

   assign in_hcount = dda_fifo_tdata_in[37:29];
   assign in_lh     = dda_fifo_tdata_in[28:21];
   assign in_map    = dda_fifo_tdata_in[19:16];
   assign next_row  = vcount_q + VC_WIDTH'(1);

   function automatic logic [15:0] wall_f(input logic [3:0] m, input logic shade);
      logic [15:0] c;
      c = {m, 1'b0, m, 2'b00, m, 1'b0};
      if (shade) c = {1'b0, m, 1'b0, m, 1'b0, 1'b0, m};
      return c;
   endfunction

   function automatic logic [15:0] pix_f(input logic [10:0] row, input logic [10:0] s,
                                         input logic [10:0] e, input logic [15:0] wall);
      if (row < s)       return CEIL_COLOR;
      else if (row >= e) return FLOOR_COLOR;
      else               return wall;
   endfunction

`ifdef RAY_SHADE_EN
   logic wt_q, wt_d;
   assign wall_in  = wall_f(in_map, dda_fifo_tdata_in[20]);
   assign wall_q   = wall_f(map_q, wt_q);
   assign unused_w = {1'b0, dda_fifo_tdata_in[15:0]};
`else
   assign wall_in  = wall_f(in_map, 1'b0);
   assign wall_q   = wall_f(map_q, 1'b0);
   assign unused_w = {dda_fifo_tdata_in[20], dda_fifo_tdata_in[15:0]};
`endif

   // Map value 0 means no wall: collapse the wall span to the horizon.
   always_comb begin
      half_s   = $signed({4'b0, in_lh[7:1]});
      start_s  = $signed(HALF_H) - half_s;
      end_s    = $signed(HALF_H) + half_s;
      in_start = (start_s < 0) ? 11'd0 : start_s;
      in_end   = (end_s > $signed(FULL_H)) ? FULL_H : end_s;
      if (in_map == 4'd0) begin
         in_start = HALF_H;
         in_end   = HALF_H;
      end
   end

   assign transformer_tready_out = rdy_q &&
      ((state_q == IDLE) || ((state_q == WAIT_FRAME) && (fb_ready_to_switch_in == 2'd3)));
   assign accept = dda_fifo_tvalid_in && transformer_tready_out;

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      end_d    = end_q;
      map_d    = map_q;
      tlast_d  = tlast_q;
      vcount_d = vcount_q;
      addr_d   = addr_q;
      pix_d    = pix_q;
      valid_d  = valid_q;
      last_d   = last_q;
      err_d    = err_q;
`ifdef RAY_SHADE_EN
      wt_d     = wt_q;
`endif
      case (state_q)
         IDLE, WAIT_FRAME: begin
            if (accept) begin
               start_d  = in_start;
               end_d    = in_end;
               map_d    = in_map;
               tlast_d  = dda_fifo_tlast_in;
`ifdef RAY_SHADE_EN
               wt_d     = dda_fifo_tdata_in[20];
`endif
               vcount_d = '0;
               addr_d   = ADDR_WIDTH'(in_hcount);
               last_d   = 1'b0;
               if ({1'b0, in_hcount} >= WIDTH_C) begin
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  state_d = dda_fifo_tlast_in ? WAIT_FRAME : IDLE;
               end else begin
                  valid_d = 1'b1;
                  pix_d   = pix_f(11'd0, in_start, in_end, wall_in);
                  state_d = RENDER;
               end
            end
         end
         RENDER: begin
            if (valid_q && pixel_ready_in) begin
               if (vcount_q == LAST_ROW) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = tlast_q ? WAIT_FRAME : IDLE;
               end else begin
                  vcount_d = next_row;
                  addr_d   = addr_q + ADDR_WIDTH'(SCREEN_WIDTH);
                  pix_d    = pix_f(11'(next_row), start_q, end_q, wall_q);
                  last_d   = tlast_q && (next_row == LAST_ROW);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         rdy_q    <= 1'b0;
         start_q  <= '0;
         end_q    <= '0;
         map_q    <= '0;
         tlast_q  <= 1'b0;
         vcount_q <= '0;
         addr_q   <= '0;
         pix_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= 1'b1;
         start_q  <= start_d;
         end_q    <= end_d;
         map_q    <= map_d;
         tlast_q  <= tlast_d;
         vcount_q <= vcount_d;
         addr_q   <= addr_d;
         pix_q    <= pix_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

`ifdef RAY_SHADE_EN
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) wt_q <= 1'b0;
      else           wt_q <= wt_d;
   end
`endif

   assign pixel_valid_out    = valid_q;
   assign ray_address_out    = addr_q;
   assign ray_pixel_out      = pix_q;
   assign ray_last_pixel_out = last_q;
   assign err_out            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_column_renderer.sv
`default_nettype none
// tb_ray_column_renderer: directed and randomized columns checked against a row-by-row colour model.
module tb_ray_column_renderer;
   localparam int W  = 320;
   localparam int H  = 180;
   localparam int AW = $clog2(W*H);
`ifdef RAY_SHADE_EN
   localparam bit SHADE = 1'b1;
`else
   localparam bit SHADE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tvalid = 1'b0;
   logic [37:0]   tdata = '0;
   logic          tlast = 1'b0;
   logic [1:0]    fb = 2'd3;
   logic          tready;
   logic          ready = 1'b1;
   logic          valid;
   logic [AW-1:0] addr;
   logic [15:0]   pix;
   logic          last;
   logic          err;

   int checks = 0;
   int errors = 0;

   ray_column_renderer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
                         .CEIL_COLOR(16'hFFFF), .FLOOR_COLOR(16'h8410)) dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n),
      .dda_fifo_tvalid_in(tvalid), .dda_fifo_tdata_in(tdata), .dda_fifo_tlast_in(tlast),
      .fb_ready_to_switch_in(fb), .transformer_tready_out(tready),
      .pixel_ready_in(ready), .pixel_valid_out(valid), .ray_address_out(addr),
      .ray_pixel_out(pix), .ray_last_pixel_out(last), .err_out(err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Colour of one row from the screen-space description of a column.
   function automatic logic [15:0] model_pix(int row, int lh, int m, int wt);
      int s, e, r, g, b;
      if (m == 0) begin
         s = H/2; e = H/2;
      end else begin
         s = H/2 - lh/2; e = H/2 + lh/2;
         if (s < 0) s = 0;
         if (e > H) e = H;
      end
      if (row < s)  return 16'hFFFF;
      if (row >= e) return 16'h8410;
      r = 2*m; g = 4*m; b = 2*m;
      if (SHADE && wt == 1) begin r = r/2; g = g/2; b = b/2; end
      return 16'(r*2048 + g*32 + b);
   endfunction

   // stall_row: -1 random backpressure, row index = 5-cycle stall there, beyond H = always ready.
   task automatic send_col(input int hc, input int lh, input int m, input int wt, input int tl,
                           input int stall_row);
      int budget, row, stalls;
      tdata  = {9'(hc), 8'(lh), 1'(wt), 4'(m), 16'($urandom)};
      tvalid = 1'b1;
      tlast  = 1'(tl);
      budget = 0;
      while (!tready && budget < 200) begin
         @(posedge clk); #1; budget++;
      end
      if (!tready) begin
         chk("tready_wait", 32'(tready), 1);
         tvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (hc >= W) begin
         chk("err_set", 32'(err), 1);
         chk("no_pixel", 32'(valid), 0);
         return;
      end
      row = 0; budget = 0; stalls = 0;
      while (row < H && budget < 3000) begin
         chk("valid", 32'(valid), 1);
         chk("addr", 32'(addr), 32'(hc + row*W));
         chk("pixel", 32'(pix), 32'(model_pix(row, lh, m, wt)));
         chk("last", 32'(last), 32'(tl == 1 && row == H-1));
         if (stall_row < 0)
            ready = ($urandom % 4) != 0;
         else if (row == stall_row && stalls < 5) begin
            ready = 1'b0; stalls++;
         end else
            ready = 1'b1;
         @(posedge clk); #1;
         if (ready) row++;
         budget++;
      end
      chk("col_done", 32'(row), 32'(H));
      chk("valid_drop", 32'(valid), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_pixel", 32'(pix), 0);
      chk("rst_last", 32'(last), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_tready", 32'(tready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("tready_before_edge", 32'(tready), 0);
      @(posedge clk); #1;
      chk("tready_after_edge", 32'(tready), 1);

      send_col(5, 60, 1, 0, 0, 9999);
      chk("tready_next", 32'(tready), 1);
      send_col(7, 255, 1, 0, 0, 9999);
      send_col(5, 60, 1, 0, 0, 10);
      send_col(12, 100, 1, 1, 0, 9999);
      send_col(20, 100, 0, 0, 0, -1);
      for (int i = 0; i < 5; i++)
         send_col($urandom_range(0, W-1), $urandom_range(0, 255), $urandom_range(0, 15),
                  $urandom_range(0, 1), 0, -1);

      fb = 2'd0;
      send_col(319, 90, 3, 0, 1, 9999);
      chk("wait_frame_tready", 32'(tready), 0);
      tdata  = {9'd100, 8'd40, 1'b0, 4'd2, 16'd0};
      tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_tready", 32'(tready), 0);
         chk("stall_valid", 32'(valid), 0);
      end
      fb = 2'd3;
      #1 chk("swap_tready", 32'(tready), 1);
      send_col(100, 40, 2, 0, 0, 9999);

      send_col(320, 60, 1, 0, 0, 9999);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("err_valid", 32'(valid), 0);
         chk("err_sticky", 32'(err), 1);
      end

      ready  = 1'b1;
      tdata  = {9'd30, 8'd80, 1'b0, 4'd5, 16'd0};
      tvalid = 1'b1;
      @(posedge clk); #1;
      tvalid = 1'b0;
      repeat (50) @(posedge clk);
      #1 chk("row50_addr", 32'(addr), 32'(30 + 50*W));
      chk("err_before_rst", 32'(err), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(valid), 0);
      chk("arst_addr", 32'(addr), 0);
      chk("arst_pixel", 32'(pix), 0);
      chk("arst_last", 32'(last), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_tready", 32'(tready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rerst_tready", 32'(tready), 1);
      send_col(150, 120, 9, 1, 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
